// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the CPU memory bus controller: FSM states, address
// decode constants and the write-lane helper.
package mem_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROM_RD,
        RAM_RD,
        RAM_WR,
        WAIT,
        DONE
    } state_t;

    localparam int   REGION_BIT = 15;
    localparam logic REGION_RAM = 1'b1;
    localparam int   WAIT_W     = 3;

    // Little-endian lane select: the low address bit picks the byte lane.
    function automatic logic [1:0] byteEnable(input logic byteWrite, input logic lsb);
        if (!byteWrite) return 2'b11;
        return lsb ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// CPU-side and memory-side signals of the bus controller. The controller
// uses the slave view; the surrounding system uses the master view.
interface mem_bus_ctrl_if;

    logic [15:0] addr_i;
    logic        re_i;
    logic        we_i;
    logic        byteWrite_i;
    logic [15:0] data_i;
    logic [15:0] data_o;
    logic        needWait_o;
    logic [13:0] rom_addr_o;
    logic        rom_re_o;
    logic [15:0] rom_data_i;
    logic [13:0] ram_addr_o;
    logic        ram_we_o;
    logic [1:0]  ram_be_o;
    logic [15:0] ram_wdata_o;
    logic [15:0] ram_rdata_i;
    logic        bus_err_o;

    modport slave (
        input  addr_i, re_i, we_i, byteWrite_i, data_i, rom_data_i, ram_rdata_i,
        output data_o, needWait_o, rom_addr_o, rom_re_o,
               ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o, bus_err_o
    );

    modport master (
        output addr_i, re_i, we_i, byteWrite_i, data_i, rom_data_i, ram_rdata_i,
        input  data_o, needWait_o, rom_addr_o, rom_re_o,
               ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o, bus_err_o
    );

endinterface

// File: rtl/mem_bus_ctrl_wait_counter.sv
// Down-counter for memory wait states: loads a count, decrements to zero
// and holds there, flagging zero.
module wait_counter
    import mem_bus_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WAIT_W-1:0] loadVal,
    input  logic              dec,
    output logic              zero
);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && (count != '0)) begin
            count <= count - WAIT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU memory bus controller: decodes ROM/RAM regions, issues exactly one
// memory access per CPU strobe, inserts wait states and stalls the CPU.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 0
) (
    input logic           clk,
    input logic           rst,
    mem_bus_ctrl_if.slave bus
);

    localparam logic [WAIT_W-1:0] ROM_WAIT_C = WAIT_W'(ROM_WAIT);
    localparam logic [WAIT_W-1:0] RAM_WAIT_C = WAIT_W'(RAM_WAIT);

    state_t state, nextState;
    state_t accKind, issueKind;

    logic [15:0]       dataQ;
    logic              busErrQ;
    logic              strobe, conflict, isRam, startAcc, errStart;
    logic              cntLoad, cntDec, cntZero;
    logic [WAIT_W-1:0] cntLoadVal;
    logic              romRe, ramWe;
    logic [1:0]        ramBe;

    assign strobe   = bus.re_i | bus.we_i;
    assign conflict = bus.re_i & bus.we_i;
    assign isRam    = (bus.addr_i[REGION_BIT] == REGION_RAM);
    assign startAcc = (state == IDLE) && strobe && !rst;

    // accKind remembers what the WAIT phase is finishing; IDLE means no data to capture.
    always_comb begin
        issueKind = IDLE;
        if (conflict)        issueKind = IDLE;
        else if (bus.we_i)   issueKind = isRam ? RAM_WR : IDLE;
        else if (bus.re_i)   issueKind = isRam ? RAM_RD : ROM_RD;
    end

    assign errStart   = startAcc && (conflict || (bus.we_i && !isRam));
    assign cntLoadVal = isRam ? RAM_WAIT_C : ROM_WAIT_C;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            accKind <= IDLE;
        end else begin
            state <= nextState;
            if (startAcc) accKind <= issueKind;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (strobe) nextState = conflict ? DONE : WAIT;
            WAIT:    if (cntZero) nextState = strobe ? DONE : IDLE;
            DONE:    if (!strobe) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        romRe   = 1'b0;
        ramWe   = 1'b0;
        ramBe   = 2'b00;
        cntLoad = 1'b0;
        cntDec  = 1'b0;
        case (state)
            IDLE: begin
                if (startAcc && !conflict) begin
                    cntLoad = 1'b1;
                    romRe   = (issueKind == ROM_RD);
                    ramWe   = (issueKind == RAM_WR);
                    if (issueKind == RAM_WR) ramBe = byteEnable(bus.byteWrite_i, bus.addr_i[0]);
                end
            end
            WAIT:    cntDec = 1'b1;
            default: ;
        endcase
    end

    wait_counter u_waitCounter (
        .clk     (clk),
        .rst     (rst),
        .load    (cntLoad),
        .loadVal (cntLoadVal),
        .dec     (cntDec),
        .zero    (cntZero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dataQ   <= '0;
            busErrQ <= 1'b0;
        end else begin
            if ((state == WAIT) && cntZero) begin
                if (accKind == ROM_RD)      dataQ <= bus.rom_data_i;
                else if (accKind == RAM_RD) dataQ <= bus.ram_rdata_i;
            end
            if (errStart) busErrQ <= 1'b1;
        end
    end

    assign bus.data_o      = dataQ;
    assign bus.bus_err_o   = busErrQ;
    assign bus.needWait_o  = strobe && (state != DONE);
    assign bus.rom_addr_o  = bus.addr_i[14:1];
    assign bus.ram_addr_o  = bus.addr_i[14:1];
    assign bus.rom_re_o    = romRe;
    assign bus.ram_we_o    = ramWe;
    assign bus.ram_be_o    = ramBe;
    // Byte data is mirrored onto both lanes; ram_be_o selects the live one.
    assign bus.ram_wdata_o = bus.byteWrite_i ? {bus.data_i[7:0], bus.data_i[7:0]} : bus.data_i;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: table of single accesses plus hand sequences for
// held strobes, ROM writes, strobe conflicts, early drop and mid-access reset.
module tb_mem_bus_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_ctrl_if bus();

    mem_bus_ctrl #(.ROM_WAIT(1), .RAM_WAIT(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [15:0] romWord(input logic [13:0] a);
        if (a == 14'd2) return 16'h0326;
        return {2'b00, a} ^ 16'hC3A5;
    endfunction

    logic [15:0] romQ = '0;
    logic [15:0] ramQ = '0;
    logic [15:0] ram [0:255] = '{default: 16'h0000};

    always @(posedge clk) begin
        if (bus.rom_re_o) romQ <= romWord(bus.rom_addr_o);
        if (bus.ram_we_o) begin
            if (bus.ram_be_o[0]) ram[bus.ram_addr_o[7:0]][7:0]  <= bus.ram_wdata_o[7:0];
            if (bus.ram_be_o[1]) ram[bus.ram_addr_o[7:0]][15:8] <= bus.ram_wdata_o[15:8];
        end
        ramQ <= ram[bus.ram_addr_o[7:0]];
    end

    assign bus.rom_data_i  = romQ;
    assign bus.ram_rdata_i = ramQ;

    int          romReCnt = 0;
    int          ramWeCnt = 0;
    logic [1:0]  capBe = '0;
    logic [13:0] capRamAddr = '0;
    logic [15:0] capWdata = '0;

    always @(negedge clk) begin
        if (bus.rom_re_o) romReCnt <= romReCnt + 1;
        if (bus.ram_we_o) begin
            ramWeCnt   <= ramWeCnt + 1;
            capBe      <= bus.ram_be_o;
            capRamAddr <= bus.ram_addr_o;
            capWdata   <= bus.ram_wdata_o;
        end
    end

    int nVec  = 0;
    int nFail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic        re;
        logic        we;
        logic        bw;
        logic [15:0] wdata;
        logic [15:0] expData;
        int          expLat;
        int          expRom;
        int          expRamWe;
        logic [1:0]  expBe;
        logic [13:0] expRamAddr;
        logic [15:0] expWmask;
        logic [15:0] expWbits;
    } vec_t;
    vec_t vecs[10];

    // Drives one strobe and counts the cycles with needWait_o high; returns at
    // the first cycle with needWait_o low (strobes still asserted).
    task automatic access(input logic [15:0] a, input logic r, input logic w,
                          input logic bw, input logic [15:0] d, output int lat);
        bus.addr_i      = a;
        bus.re_i        = r;
        bus.we_i        = w;
        bus.byteWrite_i = bw;
        bus.data_i      = d;
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!bus.needWait_o) break;
            lat++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_strobe();
        @(posedge clk);
        #1;
        bus.re_i = 1'b0;
        bus.we_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, rom0, we0;
        exp_t e;
        logic nwHist [5];

        vecs[0] = '{"rom_rd_0004", 16'h0004, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0326, 3, 1, 0, 2'b00, 14'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{"ram_bw_8001", 16'h8001, 1'b0, 1'b1, 1'b1, 16'h00AB, 16'h0326, 2, 0, 1, 2'b10, 14'h0000, 16'hFF00, 16'hAB00};
        vecs[2] = '{"ram_rd_8000", 16'h8000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hAB00, 2, 0, 0, 2'b00, 14'h0000, 16'h0000, 16'h0000};
        vecs[3] = '{"ram_ww_8000", 16'h8000, 1'b0, 1'b1, 1'b0, 16'h1234, 16'hAB00, 2, 0, 1, 2'b11, 14'h0000, 16'hFFFF, 16'h1234};
        vecs[4] = '{"ram_rd_8000b", 16'h8000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234, 2, 0, 0, 2'b00, 14'h0000, 16'h0000, 16'h0000};
        vecs[5] = '{"ram_bw_8002", 16'h8002, 1'b0, 1'b1, 1'b1, 16'h775C, 16'h1234, 2, 0, 1, 2'b01, 14'h0001, 16'h00FF, 16'h005C};
        vecs[6] = '{"ram_rd_8002", 16'h8002, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h005C, 2, 0, 0, 2'b00, 14'h0000, 16'h0000, 16'h0000};
        vecs[7] = '{"rom_rd_7ffe", 16'h7FFE, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hFC5A, 3, 1, 0, 2'b00, 14'h0000, 16'h0000, 16'h0000};
        vecs[8] = '{"ram_ww_ffff", 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'hFC5A, 2, 0, 1, 2'b11, 14'h3FFF, 16'hFFFF, 16'hBEEF};
        vecs[9] = '{"ram_rd_fffe", 16'hFFFE, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 2, 0, 0, 2'b00, 14'h0000, 16'h0000, 16'h0000};

        rst = 1'b1;
        bus.addr_i = '0; bus.re_i = 1'b0; bus.we_i = 1'b0;
        bus.byteWrite_i = 1'b0; bus.data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.data_o",     bus.data_o,     16'h0000);
        check("reset.bus_err",    bus.bus_err_o,  1'b0);
        check("reset.needWait",   bus.needWait_o, 1'b0);
        check("reset.rom_re",     bus.rom_re_o,   1'b0);
        check("reset.ram_we",     bus.ram_we_o,   1'b0);
        check("reset.ram_be",     bus.ram_be_o,   2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            rom0 = romReCnt;
            we0  = ramWeCnt;
            sbq.push_back('{vecs[i].expData, 1'b0});
            access(vecs[i].addr, vecs[i].re, vecs[i].we, vecs[i].bw, vecs[i].wdata, lat);
            e = sbq.pop_front();
            check({vecs[i].name, ".lat"},  lat,           vecs[i].expLat);
            check({vecs[i].name, ".data"}, bus.data_o,    e.data);
            check({vecs[i].name, ".err"},  bus.bus_err_o, e.err);
            release_strobe();
            check({vecs[i].name, ".rom_re_cnt"}, romReCnt - rom0, vecs[i].expRom);
            check({vecs[i].name, ".ram_we_cnt"}, ramWeCnt - we0,  vecs[i].expRamWe);
            if (vecs[i].we) begin
                check({vecs[i].name, ".be"},    capBe,                       vecs[i].expBe);
                check({vecs[i].name, ".raddr"}, capRamAddr,                  vecs[i].expRamAddr);
                check({vecs[i].name, ".wdata"}, capWdata & vecs[i].expWmask, vecs[i].expWbits);
            end
        end

        // Read held for five cycles: one access, data held, stall released.
        rom0 = romReCnt;
        we0  = ramWeCnt;
        bus.addr_i = 16'h8000;
        bus.re_i   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            nwHist[c] = bus.needWait_o;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("hold.nw0",  nwHist[0], 1'b1);
        check("hold.nw1",  nwHist[1], 1'b1);
        check("hold.nw2",  nwHist[2], 1'b0);
        check("hold.nw4",  nwHist[4], 1'b0);
        check("hold.data", bus.data_o, 16'h1234);
        release_strobe();
        check("hold.ram_we_cnt", ramWeCnt - we0,  0);
        check("hold.rom_re_cnt", romReCnt - rom0, 0);

        // Write into ROM space: normal timing, no strobe, sticky error.
        rom0 = romReCnt;
        we0  = ramWeCnt;
        sbq.push_back('{16'h1234, 1'b1});
        access(16'h0010, 1'b0, 1'b1, 1'b0, 16'hFFFF, lat);
        e = sbq.pop_front();
        check("romwr.lat",  lat,           3);
        check("romwr.data", bus.data_o,    e.data);
        check("romwr.err",  bus.bus_err_o, e.err);
        release_strobe();
        check("romwr.rom_re_cnt", romReCnt - rom0, 0);
        check("romwr.ram_we_cnt", ramWeCnt - we0,  0);

        access(16'h0004, 1'b1, 1'b0, 1'b0, 16'h0000, lat);
        check("sticky.lat",  lat,           3);
        check("sticky.data", bus.data_o,    16'h0326);
        check("sticky.err",  bus.bus_err_o, 1'b1);
        release_strobe();

        // Reset while a ROM read is in its wait phase.
        rom0 = romReCnt;
        bus.addr_i = 16'h7FFE;
        bus.re_i   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.re_i = 1'b0;
        @(negedge clk);
        check("rstwait.data",     bus.data_o,     16'h0000);
        check("rstwait.err",      bus.bus_err_o,  1'b0);
        check("rstwait.needWait", bus.needWait_o, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("rstwait.data_late",  bus.data_o,      16'h0000);
        check("rstwait.rom_re_cnt", romReCnt - rom0, 1);

        // Read and write strobes together: no access, error, one stall cycle.
        rom0 = romReCnt;
        we0  = ramWeCnt;
        access(16'h8000, 1'b1, 1'b1, 1'b0, 16'h5555, lat);
        check("conflict.lat",  lat,           1);
        check("conflict.err",  bus.bus_err_o, 1'b1);
        check("conflict.data", bus.data_o,    16'h0000);
        release_strobe();
        check("conflict.rom_re_cnt", romReCnt - rom0, 0);
        check("conflict.ram_we_cnt", ramWeCnt - we0,  0);

        // Strobe dropped after one cycle: access completes, no second access.
        rom0 = romReCnt;
        bus.addr_i = 16'h0004;
        bus.re_i   = 1'b1;
        @(posedge clk);
        #1;
        bus.re_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("drop.rom_re_cnt", romReCnt - rom0, 1);
        rom0 = romReCnt;
        access(16'h7FFE, 1'b1, 1'b0, 1'b0, 16'h0000, lat);
        check("drop.next_lat",  lat,        3);
        check("drop.next_data", bus.data_o, 16'hFC5A);
        release_strobe();
        check("drop.next_rom_re_cnt", romReCnt - rom0, 1);
        check("drop.err_sticky",      bus.bus_err_o,   1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameters: ROM_WAIT, default 1, extra wait cycles per ROM read (0..7).
REQ-002 Parameters: RAM_WAIT, default 0, extra wait cycles per RAM access (0..7).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 addr_i  in  16  CPU byte address.
REQ-006 re_i / we_i  in  1 each  CPU read / write strobe, held until needWait_o low.
REQ-007 byteWrite_i  in  1  1 = byte write, 0 = word write.
REQ-008 data_i  in  16  CPU write data; byte writes use data_i[7:0].
REQ-009 data_o  out  16  read data to CPU; the top level drives the shared data bus from it.
REQ-010 needWait_o  out  1  stall request to CPU.
REQ-011 rom_addr_o  out  14  ROM word address; rom_re_o  out  1; rom_data_i  in  16, valid one cycle after rom_re_o.
REQ-012 ram_addr_o  out  14; ram_we_o  out  1; ram_be_o  out  2; ram_wdata_o  out  16; ram_rdata_i  in  16, valid one cycle after a read.
REQ-013 bus_err_o  out  1  sticky error flag.

Function
REQ-014 Decode: addr_i[15]=0 selects ROM (0x0000-0x7FFF); addr_i[15]=1 selects RAM (0x8000-0xFFFF); word address is addr_i[14:1].
REQ-015 needWait_o is combinational: high when (re_i|we_i) and state is not DONE.
REQ-016 FSM states: IDLE, ROM_RD, RAM_RD, RAM_WR, WAIT, DONE.
REQ-017 IDLE: on re_i or we_i, issue one memory cycle (rom_re_o, or ram_we_o with ram_be_o, or a RAM read), then go to WAIT.
REQ-018 WAIT: a 3-bit counter, loaded with the region's wait count, decrements. At 0, latch the read word into data_o and go to DONE.
REQ-019 Zero-wait latency: strobe in cycle N, needWait_o high in N and N+1, data_o valid and needWait_o low from cycle N+2.
REQ-020 DONE: data_o is held and needWait_o stays low. Return to IDLE only when re_i and we_i are both low, so each strobe makes exactly one memory access.
REQ-021 Byte write: addr_i[0]=0 gives ram_be_o=01 with ram_wdata_o[7:0]=data_i[7:0]; addr_i[0]=1 gives ram_be_o=10 with ram_wdata_o[15:8]=data_i[7:0] (little-endian).
REQ-022 Word write: ram_be_o=11 and addr_i[0] is ignored.
REQ-023 Reads always return the full word; the CPU selects the byte.
REQ-024 Write to ROM: no memory strobe, bus_err_o set, normal handshake timing, data_o unchanged.
REQ-025 re_i and we_i high together in IDLE: no memory access, bus_err_o set, go directly to DONE.
REQ-026 Strobe dropped before DONE: the access finishes internally, then the FSM goes to IDLE with no second access.
REQ-027 Memory strobes are single-cycle pulses, and at most one is active per access.

Reset
REQ-028 rst forces state IDLE, wait counter 0, data_o=0x0000, bus_err_o=0, all memory strobes 0, ram_be_o=00.
REQ-029 rst mid-access aborts the access: no further strobes, and needWait_o follows REQ-015 from IDLE.
REQ-030 rst is the only way to clear bus_err_o.

Structure
REQ-031 A shared package holds the FSM state enum, the ROM/RAM region constants (REGION_BIT=15) and the wait-count width.
REQ-032 The wait counter is one sub-module, wait_counter (load, decrement, zero flag). The FSM and datapath stay in mem_bus_ctrl.

Verification
REQ-033 ROM_WAIT=1, read 0x0004 with ROM word[2]=0x0326 -> rom_addr_o=2, one rom_re_o pulse, data_o=0x0326 in cycle N+3, needWait_o high for 3 cycles.
REQ-034 RAM_WAIT=0, byte write 0xAB to 0x8001 -> ram_addr_o=0, ram_be_o=10, ram_wdata_o[15:8]=0xAB; then a word read of 0x8000 returns 0xAB00.
REQ-035 Word write 0x1234 to 0x8000, then hold re_i high for 5 cycles -> exactly one ram_we_o pulse and one RAM read; data_o=0x1234 held; needWait_o low after completion.
REQ-036 we_i to 0x0010 -> no rom_re_o and no ram_we_o; bus_err_o=1 and stays 1 until rst.
REQ-037 rst asserted during WAIT of a ROM read -> next cycle IDLE, data_o=0x0000, no further rom_re_o.
REQ-038 re_i and we_i high together -> no memory strobe, bus_err_o=1, needWait_o low after one cycle.
